cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- Sequencing FSM for the direct-mapped, write-through instruction/data cache array (128-bit lines, 32 sets, 3-bit tag, 2-bit word offset).
- Sits between the CPU load/store port, the cache array and the word-addressed main memory (1024 x 32).
- Detects hit/miss and stalls the CPU. Fetches and buffers a line on a read miss, then issues a one-cycle refill.
- Performs write-through with no-write-allocate. Keeps saturating hit/miss counters.

Parameters:
- LINE_W, 128, cache line width
- WORD_W, 32, CPU/memory word width
- ADDR_W, 10, word address width: tag[9:7], index[6:2], offset[1:0]
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- cpu_read  in  1  load request, held until cpu_stall low
- cpu_write  in  1  store request, held until cpu_stall low
- cpu_addr  in  ADDR_W  word address
- cpu_write_data  in  WORD_W  store data
- cpu_stall  out  1  request not complete this cycle
- cache_hit  in  1  hit from array (valid & tag match at driven index/tag)
- cache_tag  out  3  tag to array
- cache_index  out  5  index to array
- cache_offset  out  2  offset to array
- cache_refill  out  1  line-write strobe
- cache_update  out  1  word-write strobe
- cache_line_data  out  LINE_W  refill line (line buffer)
- cache_write_data  out  WORD_W  word for update (= cpu_write_data)
- mem_read  out  1  line read request
- mem_write  out  1  word write request
- mem_addr  out  ADDR_W  memory address
- mem_write_data  out  WORD_W  store data to memory
- mem_ready  in  1  memory completes the current request this cycle
- mem_line_data  in  LINE_W  line returned; valid when mem_ready is high during a read
- hit_count  out  CNT_W  saturating count of completed hit accesses
- miss_count  out  CNT_W  saturating count of misses

Behaviour:
- States:
  - IDLE
  - MEM_RD: mem_read=1, mem_addr={tag,index,2'b00}
  - REFILL: cache_refill=1 for exactly one cycle
  - MEM_WR: mem_write=1, mem_addr=full latched address
- Address source:
  - In IDLE, tag/index/offset come combinationally from cpu_addr. On leaving IDLE, cpu_addr and cpu_write_data are latched into addr_q/wdata_q.
  - All other states drive the cache and memory address from addr_q. mem_write_data comes from wdata_q.
- Priority: cpu_write wins if cpu_read and cpu_write are both high.
- IDLE, read, hit: cpu_stall=0; the access completes this cycle; hit_count+1.
- IDLE, read, miss: cpu_stall=1; go to MEM_RD; miss_count+1.
- IDLE, write, hit: cache_update=1 this cycle only; cpu_stall=1; go to MEM_WR; hit_count+1.
- IDLE, write, miss: no cache update; cpu_stall=1; go to MEM_WR; miss_count+1.
- MEM_RD:
  - cpu_stall=1.
  - When mem_ready is high, capture mem_line_data into line_buf and go to REFILL.
  - If mem_ready is low, stay.
- REFILL: cache_line_data=line_buf; cpu_stall=1; next state IDLE. The held read then hits in IDLE without a second count, because a flag set in REFILL suppresses hit_count for that retry.
- MEM_WR:
  - cpu_stall=1 until mem_ready.
  - In the mem_ready cycle, cpu_stall=0 (the store completes) and the next state is IDLE.
- mem_read and mem_write are never high together. Each stays asserted continuously until mem_ready.
- Latency with memory latency L (cycles from first request cycle to mem_ready, L>=1):
  - read hit: 0 stall cycles
  - read miss: L+2 stall cycles
  - write: L stall cycles
- Counters saturate at 2^CNT_W-1 and never wrap.
- No request in IDLE: all strobes low, cpu_stall=0.
- Reset (any state, including mid-MEM_RD/MEM_WR):
  - next state IDLE; mem_read, mem_write, cache_refill and cache_update low the cycle after reset is sampled
  - counters=0, line_buf=0, addr_q=0
  - an in-flight memory response is ignored

Test Plan:
- Read 0x2A5 (tag 5, index 9, offset 1) on a cold cache, memory L=3 returning line 0x...DDDD_CCCC_BBBB_AAAA -> mem_read for 3 cycles at mem_addr 0x2A4, then one refill cycle, then cpu_stall=0 in the next cycle with a hit; total stall 5 cycles; miss_count=1, hit_count=0.
- Read 0x2A5 again -> no stall, hit; hit_count=1.
- Write 0xDEADBEEF to 0x2A6 (hit), L=2 -> cache_update pulse in cycle 0, mem_write with mem_addr 0x2A6 and data 0xDEADBEEF for 2 cycles, stall low in cycle 2; hit_count=2.
- Write to 0x100 (miss), L=1 -> no cache_update, one mem_write cycle, miss_count increments; a following read of 0x100 still misses.
- Assert reset_n=0 during MEM_RD cycle 2 -> IDLE next cycle, mem_read low, counters 0; a late mem_ready is ignored and cache_refill stays low.
- Preload miss_count to 0xFFFF via repeated misses (or force) and miss once more -> the value stays 0xFFFF.

Source files
------------

// File: rtl/cache_controller.sv
// Sequencer for a direct-mapped write-through cache: hit/miss detection,
// line refill on read miss, no-write-allocate stores, saturating counters.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   cpu_read/cpu_write      held requests; cpu_addr/cpu_write_data operands
//   cpu_stall               request not complete this cycle
//   cache_hit               array hit for the driven tag/index
//   cache_tag/index/offset  address to the array
//   cache_refill/update     line-write / word-write strobes
//   cache_line_data         refill line (line buffer)
//   cache_write_data        word for update
//   mem_read/mem_write      memory requests, held until mem_ready
//   mem_addr/mem_write_data memory address and store data
//   mem_ready/mem_line_data memory completion and returned line
//   hit_count/miss_count    saturating performance counters
module cache_controller #(
  parameter int LINE_W = 128,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_write_data,
  output logic              cpu_stall,
  input  logic              cache_hit,
  output logic [2:0]        cache_tag,
  output logic [4:0]        cache_index,
  output logic [1:0]        cache_offset,
  output logic              cache_refill,
  output logic              cache_update,
  output logic [LINE_W-1:0] cache_line_data,
  output logic [WORD_W-1:0] cache_write_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_write_data,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_line_data,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  typedef enum logic [1:0] {
    IDLE,
    MEM_RD,
    REFILL,
    MEM_WR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [LINE_W-1:0]   line_q;
  logic [CNT_W-1:0]    hit_q, miss_q;
  logic                retry_q;

  logic [ADDR_W-1:0]   addr_d;
  logic                latch_d, cap_d;
  logic                inc_hit, inc_miss;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    latch_d      = 1'b0;
    cap_d        = 1'b0;
    inc_hit      = 1'b0;
    inc_miss     = 1'b0;
    cpu_stall    = 1'b0;
    cache_update = 1'b0;
    cache_refill = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    unique case (state_q)
      IDLE: begin
        addr_d = cpu_addr;
        if (cpu_write) begin
          cpu_stall    = 1'b1;
          cache_update = cache_hit;
          latch_d      = 1'b1;
          inc_hit      = cache_hit;
          inc_miss     = !cache_hit;
          state_d      = MEM_WR;
        end else if (cpu_read) begin
          if (cache_hit) begin
            // retry right after a refill was already counted as a miss
            inc_hit = !retry_q;
          end else begin
            cpu_stall = 1'b1;
            latch_d   = 1'b1;
            inc_miss  = 1'b1;
            state_d   = MEM_RD;
          end
        end
      end
      MEM_RD: begin
        cpu_stall = 1'b1;
        mem_read  = 1'b1;
        if (mem_ready) begin
          cap_d   = 1'b1;
          state_d = REFILL;
        end
      end
      REFILL: begin
        cpu_stall    = 1'b1;
        cache_refill = 1'b1;
        state_d      = IDLE;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        cpu_stall = !mem_ready;
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cache_tag        = addr_d[9:7];
  assign cache_index      = addr_d[6:2];
  assign cache_offset     = addr_d[1:0];
  assign mem_addr         = mem_read ? {addr_d[9:2], 2'b00} : addr_d;
  assign mem_write_data   = wdata_q;
  assign cache_write_data = cpu_write_data;
  assign cache_line_data  = line_q;
  assign hit_count        = hit_q;
  assign miss_count       = miss_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      retry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= (state_q == REFILL);
      if (latch_d) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_write_data;
      end
      if (cap_d) line_q <= mem_line_data;
      if (inc_hit && hit_q != '1) hit_q <= hit_q + 1'b1;
      if (inc_miss && miss_q != '1) miss_q <= miss_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: miss/refill, hits, write-through,
// priority, mid-read reset and counter saturation (narrow counters).
`define CHK(t, g, e) chk(t, 128'(g), 128'(e))

module tb_cache_controller;

  localparam int CW = 8;
  localparam logic [127:0] LINE =
    128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_read, cpu_write;
  logic [9:0]    cpu_addr;
  logic [31:0]   cpu_write_data;
  logic          cpu_stall;
  logic          cache_hit;
  logic [2:0]    cache_tag;
  logic [4:0]    cache_index;
  logic [1:0]    cache_offset;
  logic          cache_refill, cache_update;
  logic [127:0]  cache_line_data;
  logic [31:0]   cache_write_data;
  logic          mem_read, mem_write;
  logic [9:0]    mem_addr;
  logic [31:0]   mem_write_data;
  logic          mem_ready;
  logic [127:0]  mem_line_data;
  logic [CW-1:0] hit_count, miss_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_controller #(.CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
    .cpu_stall(cpu_stall), .cache_hit(cache_hit),
    .cache_tag(cache_tag), .cache_index(cache_index),
    .cache_offset(cache_offset), .cache_refill(cache_refill),
    .cache_update(cache_update), .cache_line_data(cache_line_data),
    .cache_write_data(cache_write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_ready(mem_ready), .mem_line_data(mem_line_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  task automatic chk(input string t, input logic [127:0] g,
                     input logic [127:0] e);
    n_vec++;
    assert (g === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", t, g, e);
    end
  endtask

  always @(posedge clk) begin
    if (reset_n === 1'b1) begin
      n_vec++;
      if ((mem_read & mem_write) === 1'b1) begin
        n_err++;
        $error("FAIL inv_rw: mem_read and mem_write both high");
      end
      if (cache_refill === 1'b1 && cpu_stall !== 1'b1) begin
        n_err++;
        $error("FAIL inv_refill: refill without stall");
      end
    end
  end

  // inputs change 1 time unit after the edge, checks 1 unit later
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 0; cpu_read = 0; cpu_write = 0;
    cpu_addr = '0; cpu_write_data = '0;
    cache_hit = 0; mem_ready = 0; mem_line_data = '0;
    tick(); tick();
    reset_n = 1;
    #1;
    `CHK("rst_stall", cpu_stall, 0);
    `CHK("rst_mrd", mem_read, 0);
    `CHK("rst_mwr", mem_write, 0);
    `CHK("rst_hit", hit_count, 0);
    `CHK("rst_miss", miss_count, 0);
    `CHK("rst_line", cache_line_data, 0);

    // cold read miss, L=3
    tick();
    cpu_read = 1; cpu_addr = 10'h2A5; cache_hit = 0;
    #1;
    `CHK("rm0_stall", cpu_stall, 1);
    `CHK("rm0_tag", cache_tag, 5);
    `CHK("rm0_idx", cache_index, 9);
    `CHK("rm0_off", cache_offset, 1);
    `CHK("rm0_mrd", mem_read, 0);
    tick();
    #1;
    `CHK("rm1_mrd", mem_read, 1);
    `CHK("rm1_addr", mem_addr, 10'h2A4);
    `CHK("rm1_stall", cpu_stall, 1);
    `CHK("rm1_miss", miss_count, 1);
    tick();
    #1;
    `CHK("rm2_mrd", mem_read, 1);
    tick();
    mem_ready = 1; mem_line_data = LINE;
    #1;
    `CHK("rm3_mrd", mem_read, 1);
    `CHK("rm3_refill", cache_refill, 0);
    tick();
    mem_ready = 0; mem_line_data = '0;
    #1;
    `CHK("rf_refill", cache_refill, 1);
    `CHK("rf_line", cache_line_data, LINE);
    `CHK("rf_stall", cpu_stall, 1);
    `CHK("rf_mrd", mem_read, 0);
    `CHK("rf_idx", cache_index, 9);
    tick();
    cache_hit = 1;
    #1;
    `CHK("rt_stall", cpu_stall, 0);
    `CHK("rt_refill", cache_refill, 0);
    tick();
    cpu_read = 0; cache_hit = 0;
    #1;
    `CHK("rt_hit", hit_count, 0);
    `CHK("rt_miss", miss_count, 1);

    // read hit
    tick();
    cpu_read = 1; cpu_addr = 10'h2A5; cache_hit = 1;
    #1;
    `CHK("rh_stall", cpu_stall, 0);
    `CHK("rh_mrd", mem_read, 0);
    tick();
    cpu_read = 0; cache_hit = 0;
    #1;
    `CHK("rh_hit", hit_count, 1);

    // write hit, L=2
    tick();
    cpu_write = 1; cpu_addr = 10'h2A6;
    cpu_write_data = 32'hDEADBEEF; cache_hit = 1;
    #1;
    `CHK("wh0_upd", cache_update, 1);
    `CHK("wh0_wd", cache_write_data, 32'hDEADBEEF);
    `CHK("wh0_stall", cpu_stall, 1);
    `CHK("wh0_mwr", mem_write, 0);
    tick();
    cache_hit = 0;
    #1;
    `CHK("wh1_upd", cache_update, 0);
    `CHK("wh1_mwr", mem_write, 1);
    `CHK("wh1_addr", mem_addr, 10'h2A6);
    `CHK("wh1_data", mem_write_data, 32'hDEADBEEF);
    `CHK("wh1_stall", cpu_stall, 1);
    `CHK("wh1_hit", hit_count, 2);
    tick();
    mem_ready = 1;
    #1;
    `CHK("wh2_mwr", mem_write, 1);
    `CHK("wh2_stall", cpu_stall, 0);
    tick();
    cpu_write = 0; mem_ready = 0;
    #1;
    `CHK("wh3_mwr", mem_write, 0);
    `CHK("wh3_stall", cpu_stall, 0);

    // write miss with read also high (write wins), L=1
    tick();
    cpu_write = 1; cpu_read = 1; cpu_addr = 10'h100;
    cpu_write_data = 32'h1234_5678; cache_hit = 0;
    #1;
    `CHK("wm0_upd", cache_update, 0);
    `CHK("wm0_stall", cpu_stall, 1);
    tick();
    mem_ready = 1;
    #1;
    `CHK("wm1_mwr", mem_write, 1);
    `CHK("wm1_mrd", mem_read, 0);
    `CHK("wm1_addr", mem_addr, 10'h100);
    `CHK("wm1_data", mem_write_data, 32'h1234_5678);
    `CHK("wm1_stall", cpu_stall, 0);
    `CHK("wm1_miss", miss_count, 2);

    // read of 0x100 still misses; reset in MEM_RD cycle 2
    tick();
    cpu_write = 0; mem_ready = 0;
    #1;
    `CHK("ra0_stall", cpu_stall, 1);
    tick();
    #1;
    `CHK("ra1_mrd", mem_read, 1);
    `CHK("ra1_addr", mem_addr, 10'h100);
    `CHK("ra1_miss", miss_count, 3);
    tick();
    reset_n = 0; cpu_read = 0;
    #1;
    `CHK("ra2_mrd", mem_read, 1);
    tick();
    reset_n = 1; mem_ready = 1; mem_line_data = LINE;
    #1;
    `CHK("rs_mrd", mem_read, 0);
    `CHK("rs_refill", cache_refill, 0);
    `CHK("rs_stall", cpu_stall, 0);
    `CHK("rs_hit", hit_count, 0);
    `CHK("rs_miss", miss_count, 0);
    `CHK("rs_line", cache_line_data, 0);
    tick();
    mem_ready = 0; mem_line_data = '0;
    #1;
    `CHK("rs1_refill", cache_refill, 0);
    `CHK("rs1_mrd", mem_read, 0);

    // saturation: held write miss with instant memory, 2 cycles each
    cpu_write = 1; cpu_addr = 10'h3FF; cache_hit = 0; mem_ready = 1;
    repeat (2 * ((1 << CW) - 1)) tick();
    cpu_write = 0;
    #1;
    `CHK("sat_full", miss_count, {CW{1'b1}});
    cpu_write = 1;
    tick(); tick();
    cpu_write = 0; mem_ready = 0;
    #1;
    `CHK("sat_hold", miss_count, {CW{1'b1}});
    `CHK("sat_hit", hit_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
